instr_encoder: RTL and testbench

- Encoder side of the 4-bit-opcode control decoder.
- Accepts symbolic operation requests over a valid/ready handshake, packs each into a 9-bit machine word and writes it sequentially into instruction memory from a loadable base address.
- Used by the bench/program loader to build programs; the words it emits are the exact encodings the core's control decoder consumes.

---
 rtl/instr_encoder_pkg.sv | 32 +++
 rtl/instr_encoder_if.sv | 27 ++
 rtl/instr_encoder_pack.sv | 40 ++++
 rtl/instr_encoder.sv | 103 ++++++++++
 tb/tb_instr_encoder.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared opcode definitions for the instruction encoder and the core's control decoder.
// 3-bit classes pack {op3, rd, rs}; 4-bit classes pack {op4, imm[4:0]}.
package instr_pkg;

   typedef enum logic [3:0] {
      KIND_ADD   = 4'd0,
      KIND_MOV   = 4'd1,
      KIND_XOR   = 4'd2,
      KIND_LOAD  = 4'd3,
      KIND_STORE = 4'd4,
      KIND_LSH   = 4'd5,
      KIND_AND   = 4'd6,
      KIND_BNE   = 4'd7,
      KIND_SET   = 4'd8,
      KIND_HALT  = 4'd9
   } op_kind_t;

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_MOV   = 3'b001;
   localparam logic [2:0] OP_XOR   = 3'b010;
   localparam logic [2:0] OP_LOAD  = 3'b011;
   localparam logic [2:0] OP_STORE = 3'b100;
   localparam logic [2:0] OP_LSH   = 3'b101;
   localparam logic [2:0] OP_AND   = 3'b111;

   localparam logic [3:0] OP_BNE   = 4'b1100;
   localparam logic [3:0] OP_SET   = 4'b1101;

   localparam int unsigned IMM_MAX = 31;
   localparam int unsigned WORD_W  = 9;

endpackage

// File: rtl/instr_encoder_if.sv
// Request channel into the encoder and its instruction-memory write port.
interface instr_encoder_if #(
   parameter int unsigned PC_W = 8
);
   import instr_pkg::*;

   logic              op_valid;
   logic              op_ready;
   logic [3:0]        op_kind;
   logic [2:0]        rd;
   logic [2:0]        rs;
   logic [7:0]        imm;
   logic              im_we;
   logic [PC_W-1:0]   im_addr;
   logic [WORD_W-1:0] im_wdata;

   modport master (
      output op_valid, op_kind, rd, rs, imm,
      input  op_ready, im_we, im_addr, im_wdata
   );

   modport slave (
      input  op_valid, op_kind, rd, rs, imm,
      output op_ready, im_we, im_addr, im_wdata
   );

endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational packer: symbolic request -> 9-bit machine word plus legality flag.
module instr_pack
   import instr_pkg::*;
(
   input  logic [3:0]        op_kind,
   input  logic [2:0]        rd,
   input  logic [2:0]        rs,
   input  logic [7:0]        imm,
   output logic [WORD_W-1:0] word,
   output logic              legal
);

   logic imm_ok;
   assign imm_ok = (imm <= 8'(IMM_MAX));

   always_comb begin
      word  = '0;
      legal = 1'b1;
      case (op_kind)
         KIND_ADD:   word = {OP_ADD,   rd, rs};
         KIND_MOV:   word = {OP_MOV,   rd, rs};
         KIND_XOR:   word = {OP_XOR,   rd, rs};
         KIND_LOAD:  word = {OP_LOAD,  rd, rs};
         KIND_STORE: word = {OP_STORE, rd, rs};
         KIND_LSH:   word = {OP_LSH,   rd, rs};
         KIND_AND:   word = {OP_AND,   rd, rs};
         KIND_BNE: begin
            word  = {OP_BNE, imm[4:0]};
            legal = imm_ok;
         end
         KIND_SET: begin
            word  = {OP_SET, imm[4:0]};
            legal = imm_ok;
         end
         KIND_HALT:  legal = 1'b1;
         default:    legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Program loader FSM: accepts encode requests and writes one word per two cycles
// into instruction memory starting at a loadable base address.
module instr_encoder
   import instr_pkg::*;
#(
   parameter int unsigned PC_W      = 8,
   parameter int unsigned MEM_DEPTH = 256
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             start,
   input  logic [PC_W-1:0]  base_addr,
   output logic [PC_W:0]    word_count,
   output logic             done,
   output logic             err,
   instr_encoder_if.slave   bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_WRITE, S_DONE} state_t;

   localparam logic [PC_W:0] DEPTH = (PC_W+1)'(MEM_DEPTH);

   state_t            state;
   logic [PC_W:0]     pc;
   logic              ready_q;
   logic [WORD_W-1:0] word;
   logic              legal;
   logic              accept;
   logic              is_halt;
   logic              full;

   instr_pack u_pack (
      .op_kind (bus.op_kind),
      .rd      (bus.rd),
      .rs      (bus.rs),
      .imm     (bus.imm),
      .word    (word),
      .legal   (legal)
   );

   // start blocks acceptance in the same cycle so it always wins over a request.
   assign bus.op_ready = ready_q & ~start;
   assign accept       = bus.op_valid & bus.op_ready;
   assign is_halt      = (bus.op_kind == 4'(KIND_HALT));
   assign full         = (pc >= DEPTH);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= S_IDLE;
         pc           <= '0;
         ready_q      <= 1'b0;
         word_count   <= '0;
         done         <= 1'b0;
         err          <= 1'b0;
         bus.im_we    <= 1'b0;
         bus.im_addr  <= '0;
         bus.im_wdata <= '0;
      end else begin
         bus.im_we <= 1'b0;
         if (start) begin
            // A strobe already on the bus this cycle finishes; its pc advance is dropped.
            state      <= S_RUN;
            pc         <= {1'b0, base_addr};
            ready_q    <= ({1'b0, base_addr} < DEPTH);
            word_count <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
         end else begin
            case (state)
               S_RUN: begin
                  if (accept) begin
                     if (is_halt) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        ready_q <= 1'b0;
                     end else if (legal) begin
                        state        <= S_WRITE;
                        ready_q      <= 1'b0;
                        bus.im_we    <= 1'b1;
                        bus.im_addr  <= pc[PC_W-1:0];
                        bus.im_wdata <= word;
                     end else begin
                        err <= 1'b1;
                     end
                  end else if (full && bus.op_valid) begin
                     err <= 1'b1;
                  end
               end
               S_WRITE: begin
                  state      <= S_RUN;
                  pc         <= pc + 1'b1;
                  word_count <= word_count + 1'b1;
                  ready_q    <= ((pc + 1'b1) < DEPTH);
               end
               S_IDLE: ready_q <= 1'b0;
               S_DONE: ready_q <= 1'b0;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// programs compared against an arithmetic encoding model.
module tb_instr_encoder;
   import instr_pkg::*;

   localparam int unsigned PC_W      = 8;
   localparam int unsigned MEM_DEPTH = 256;

   logic            Clk = 1'b0;
   logic            Reset = 1'b1;
   logic            start = 1'b0;
   logic [PC_W-1:0] base_addr = '0;
   logic [PC_W:0]   word_count;
   logic            done;
   logic            err;

   instr_encoder_if #(.PC_W(PC_W)) bus ();

   instr_encoder #(.PC_W(PC_W), .MEM_DEPTH(MEM_DEPTH)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .done       (done),
      .err        (err),
      .bus        (bus)
   );

   always #5 Clk = ~Clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned wr_addr[$];
   int unsigned wr_data[$];
   int unsigned exp_addr[$];
   int unsigned exp_data[$];
   bit          rdy_log[$];

   always @(negedge Clk) begin
      if (bus.im_we === 1'b1) begin
         wr_addr.push_back(int'(bus.im_addr));
         wr_data.push_back(int'(bus.im_wdata));
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference encoding: opcode value shifted into the top field by multiplication.
   function automatic int unsigned ref_word(input int unsigned k, input int unsigned rdv,
                                            input int unsigned rsv, input int unsigned immv);
      int unsigned op3[7] = '{0, 1, 2, 3, 4, 5, 7};
      if (k < 7) return op3[k] * 64 + rdv * 8 + rsv;
      if (k == 7) return 12 * 32 + immv;
      return 13 * 32 + immv;
   endfunction

   function automatic bit ref_writes(input int unsigned k, input int unsigned immv);
      return (k <= 6) || ((k == 7 || k == 8) && immv <= 31);
   endfunction

   task automatic send_op(input int unsigned k, input int unsigned rdv, input int unsigned rsv,
                          input int unsigned immv, input int unsigned budget, output bit acc);
      int unsigned n = 0;
      bit got;
      acc = 1'b0;
      @(negedge Clk);
      bus.op_valid = 1'b1;
      bus.op_kind  = 4'(k);
      bus.rd       = 3'(rdv);
      bus.rs       = 3'(rsv);
      bus.imm      = 8'(immv);
      while (!acc && n < budget) begin
         #1 got = bus.op_ready;
         rdy_log.push_back(got);
         @(posedge Clk);
         if (got) acc = 1'b1;
         else begin
            n++;
            @(negedge Clk);
         end
      end
   endtask

   task automatic expect_op(input string tag, input int unsigned k, input int unsigned rdv,
                            input int unsigned rsv, input int unsigned immv);
      bit acc;
      send_op(k, rdv, rsv, immv, 20, acc);
      check({tag, "_accept"}, 32'(acc), 32'd1);
   endtask

   task automatic idle(input int unsigned cycles);
      @(negedge Clk);
      bus.op_valid = 1'b0;
      repeat (cycles) @(negedge Clk);
   endtask

   task automatic do_start(input int unsigned b);
      @(negedge Clk);
      bus.op_valid = 1'b0;
      start        = 1'b1;
      base_addr    = PC_W'(b);
      @(negedge Clk);
      start        = 1'b0;
   endtask

   task automatic check_writes(input string tag);
      check({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(exp_addr.size()));
      for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
         check({tag, "_addr"}, wr_addr[i], exp_addr[i]);
         check({tag, "_data"}, wr_data[i], exp_data[i]);
      end
      wr_addr.delete();
      wr_data.delete();
      exp_addr.delete();
      exp_data.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit acc;
      bus.op_valid = 1'b0;
      bus.op_kind  = '0;
      bus.rd       = '0;
      bus.rs       = '0;
      bus.imm      = '0;

      repeat (3) @(negedge Clk);
      check("rst_ready", 32'(bus.op_ready), 32'd0);
      check("rst_we",    32'(bus.im_we), 32'd0);
      check("rst_addr",  32'(bus.im_addr), 32'd0);
      check("rst_wdata", 32'(bus.im_wdata), 32'd0);
      check("rst_count", 32'(word_count), 32'd0);
      check("rst_done",  32'(done), 32'd0);
      check("rst_err",   32'(err), 32'd0);
      Reset = 1'b0;
      wr_addr.delete();
      wr_data.delete();

      // ADD then HALT
      do_start(16);
      expect_op("t1_add", 4'(KIND_ADD), 2, 5, 0);
      expect_op("t1_halt", 4'(KIND_HALT), 0, 0, 0);
      idle(2);
      exp_addr.push_back(16); exp_data.push_back(9'b000_010_101);
      check_writes("t1");
      check("t1_done", 32'(done), 32'd1);
      check("t1_count", 32'(word_count), 32'd1);
      check("t1_err", 32'(err), 32'd0);

      // back-to-back with op_valid held
      do_start(0);
      rdy_log.delete();
      expect_op("t2_set", 4'(KIND_SET), 0, 0, 7);
      expect_op("t2_bne", 4'(KIND_BNE), 0, 0, 31);
      expect_op("t2_load", 4'(KIND_LOAD), 1, 3, 0);
      idle(2);
      check("t2_rdy_len", 32'(rdy_log.size()), 32'd5);
      for (int i = 0; i < rdy_log.size(); i++)
         check("t2_rdy_toggle", 32'(rdy_log[i]), 32'((i % 2) == 0));
      exp_addr.push_back(0); exp_data.push_back(9'b1101_00111);
      exp_addr.push_back(1); exp_data.push_back(9'b1100_11111);
      exp_addr.push_back(2); exp_data.push_back(9'b011_001_011);
      check_writes("t2");
      check("t2_err", 32'(err), 32'd0);
      check("t2_count", 32'(word_count), 32'd3);

      // out-of-range immediate is consumed without advancing pc
      do_start(8'h40);
      expect_op("t3_set", 4'(KIND_SET), 0, 0, 32);
      idle(1);
      check("t3_err", 32'(err), 32'd1);
      expect_op("t3_mov", 4'(KIND_MOV), 0, 1, 0);
      idle(2);
      exp_addr.push_back(8'h40); exp_data.push_back(9'b001_000_001);
      check_writes("t3");
      check("t3_count", 32'(word_count), 32'd1);

      // last legal address, then full
      do_start(MEM_DEPTH - 1);
      expect_op("t4_st0", 4'(KIND_STORE), 3, 4, 0);
      send_op(4'(KIND_STORE), 1, 2, 0, 6, acc);
      check("t4_full_accept", 32'(acc), 32'd0);
      check("t4_full_ready", 32'(bus.op_ready), 32'd0);
      check("t4_full_err", 32'(err), 32'd1);
      idle(2);
      exp_addr.push_back(MEM_DEPTH - 1); exp_data.push_back(9'b100_011_100);
      check_writes("t4");
      check("t4_count", 32'(word_count), 32'd1);

      // start beats a simultaneous request
      @(negedge Clk);
      start = 1'b1; base_addr = 8'h20;
      bus.op_valid = 1'b1; bus.op_kind = 4'(KIND_ADD); bus.rd = 3'd1; bus.rs = 3'd1;
      #1 check("t5_ready_on_start", 32'(bus.op_ready), 32'd0);
      @(negedge Clk);
      start = 1'b0; bus.op_valid = 1'b0;
      idle(2);
      check_writes("t5_none");
      check("t5_count", 32'(word_count), 32'd0);
      expect_op("t5_mov", 4'(KIND_MOV), 2, 3, 0);
      idle(2);
      exp_addr.push_back(8'h20); exp_data.push_back(9'b001_010_011);
      check_writes("t5");

      // Reset during a write
      do_start(8'h30);
      expect_op("t6_bad", 4'(KIND_BNE), 0, 0, 40);
      expect_op("t6_add", 4'(KIND_ADD), 7, 7, 0);
      @(negedge Clk);
      Reset = 1'b1; bus.op_valid = 1'b0;
      @(negedge Clk);
      check("t6_we", 32'(bus.im_we), 32'd0);
      check("t6_addr", 32'(bus.im_addr), 32'd0);
      check("t6_wdata", 32'(bus.im_wdata), 32'd0);
      check("t6_count", 32'(word_count), 32'd0);
      check("t6_done", 32'(done), 32'd0);
      check("t6_err", 32'(err), 32'd0);
      check("t6_ready", 32'(bus.op_ready), 32'd0);
      Reset = 1'b0;
      wr_addr.delete(); wr_data.delete();
      send_op(4'(KIND_ADD), 1, 1, 0, 3, acc);
      check("t6_idle_accept", 32'(acc), 32'd0);
      idle(2);
      check_writes("t6_none");

      // randomized programs
      for (int r = 0; r < 3; r++) begin
         int unsigned b;
         int unsigned pc;
         bit e;
         b  = $urandom_range(0, 200);
         pc = b;
         e  = 1'b0;
         do_start(b);
         for (int i = 0; i < 40; i++) begin
            int unsigned k, rdv, rsv, immv;
            k    = $urandom_range(0, 15);
            if (k == 9) k = 0;
            rdv  = $urandom_range(0, 7);
            rsv  = $urandom_range(0, 7);
            immv = $urandom_range(0, 63);
            expect_op("rnd", k, rdv, rsv, immv);
            if (ref_writes(k, immv)) begin
               exp_addr.push_back(pc);
               exp_data.push_back(ref_word(k, rdv, rsv, immv));
               pc++;
            end else e = 1'b1;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
         end
         expect_op("rnd_halt", 4'(KIND_HALT), 0, 0, 0);
         idle(2);
         check_writes("rnd");
         check("rnd_err", 32'(err), 32'(e));
         check("rnd_count", 32'(word_count), pc - b);
         check("rnd_done", 32'(done), 32'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
